// File: rtl/pll_reset_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer and its helpers.
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    S_PLLRST = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_RUN    = 2'd3
  } seq_state_t;

  localparam int CNT_W_DEF = 20;
  localparam int RELOCK_W  = 8;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser for bringing an asynchronous level into clk.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset; re-pulses the PLL if lock never arrives.
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int RELOCK_TIMEOUT = 1048576,
  parameter int HOLD_CYCLES    = 1024,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                locked,
  output logic                pll_rst,
  output logic                sys_rst,
  output logic                ready,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [1:0]          state
);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  seq_state_t          cur_state, next_state;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [RELOCK_W-1:0] relock_next;
  logic                locked_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clkin),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // Outputs are registered from next_state so they move with the state register.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cur_state    <= S_PLLRST;
      cnt          <= '0;
      relock_count <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
    end else begin
      cur_state    <= next_state;
      cnt          <= cnt_next;
      relock_count <= relock_next;
      pll_rst      <= (next_state == S_PLLRST);
      sys_rst      <= (next_state != S_RUN);
      ready        <= (next_state == S_RUN);
    end
  end

  // Lock loss beats a simultaneous terminal count, and lock beats a timeout.
  always_comb begin
    next_state  = cur_state;
    cnt_next    = cnt + CNT_W'(1);
    relock_next = relock_count;
    unique case (cur_state)
      S_PLLRST: begin
        if (cnt == PLL_LAST) begin
          next_state = S_WAIT;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        if (locked_s) begin
          next_state = S_HOLD;
          cnt_next   = '0;
        end else if (cnt == WAIT_LAST) begin
          next_state = S_PLLRST;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (!locked_s) begin
          next_state = S_WAIT;
          cnt_next   = '0;
        end else if (cnt == HOLD_LAST) begin
          next_state = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        cnt_next = '0;
        if (!locked_s) begin
          next_state = S_WAIT;
          if (relock_count != '1) relock_next = relock_count + RELOCK_W'(1);
        end
      end
      default: begin
        next_state = S_PLLRST;
        cnt_next   = '0;
      end
    endcase
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed vectors plus a timeline model compared every cycle.
module tb_pll_reset_seq;

  localparam int SYNC_STAGES    = 2;
  localparam int PLL_RST_CYCLES = 4;
  localparam int RELOCK_TIMEOUT = 32;
  localparam int HOLD_CYCLES    = 8;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [7:0] relock_count;
  logic [1:0] state;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  pll_reset_seq #(
    .SYNC_STAGES   (SYNC_STAGES),
    .PLL_RST_CYCLES(PLL_RST_CYCLES),
    .RELOCK_TIMEOUT(RELOCK_TIMEOUT),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .CNT_W         (20)
  ) dut (
    .clkin       (clkin),
    .rst         (rst),
    .locked      (locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .relock_count(relock_count),
    .state       (state)
  );

  always #10 clkin = ~clkin;

  // Timeline model: mode is the phase, ticks are edges already spent in it,
  // lockHist is the delay line that makes a lock change visible late.
  int mMode = 0;
  int mTicks = 0;
  int mRelocks = 0;
  bit lockHist [SYNC_STAGES];
  bit mLs;

  always @(posedge clkin) begin
    mLs = lockHist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) lockHist[i] = lockHist[i-1];
    lockHist[0] = locked;
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) lockHist[i] = 1'b0;
      mMode = 0; mTicks = 0; mRelocks = 0;
    end else begin
      case (mMode)
        0: if (mTicks + 1 >= PLL_RST_CYCLES) begin mMode = 1; mTicks = 0; end
           else mTicks++;
        1: if (mLs) begin mMode = 2; mTicks = 0; end
           else if (mTicks + 1 >= RELOCK_TIMEOUT) begin mMode = 0; mTicks = 0; end
           else mTicks++;
        2: if (!mLs) begin mMode = 1; mTicks = 0; end
           else if (mTicks + 1 >= HOLD_CYCLES) begin mMode = 3; mTicks = 0; end
           else mTicks++;
        default: if (!mLs) begin
             mMode = 1; mTicks = 0;
             if (mRelocks < 255) mRelocks++;
           end
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clkin);
    #1;
    if (checkEn) begin
      checkOutput("model_pll_rst", pll_rst, mMode == 0);
      checkOutput("model_sys_rst", sys_rst, mMode != 3);
      checkOutput("model_ready", ready, mMode == 3);
      checkOutput("model_state", state, mMode);
      checkOutput("model_relock", relock_count, mRelocks);
    end
  end

  // Inputs change on the falling edge; returns #1 after the n-th rising edge.
  task automatic applyStimulus(input logic r, input logic l, input int n);
    @(negedge clkin);
    rst = r;
    locked = l;
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic relockCycle();
    int waited;
    applyStimulus(1'b0, 1'b0, 4);
    applyStimulus(1'b0, 1'b1, 1);
    waited = 0;
    while (state != 2'd3 && waited < 40) begin
      applyStimulus(1'b0, 1'b1, 1);
      waited++;
    end
    if (state != 2'd3) checkOutput("relock_run_timeout", state, 3);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b1, 3);
    checkEn = 1'b1;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_pll_rst", pll_rst, 1);
    checkOutput("reset_ready", ready, 0);

    // Cold start with lock already present.
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("cold_pll_e3", pll_rst, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("cold_pll_e4", pll_rst, 0);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("cold_sys_e12", sys_rst, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("cold_sys_e13", sys_rst, 0);
    checkOutput("cold_ready_e13", ready, 1);
    checkOutput("cold_state_e13", state, 3);

    // Lock drop while running, regained before the timeout.
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("drop_sys_e2", sys_rst, 0);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("drop_sys_e3", sys_rst, 1);
    checkOutput("drop_ready_e3", ready, 0);
    checkOutput("drop_relock", relock_count, 1);
    applyStimulus(1'b0, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 15);
    checkOutput("drop_back_run", state, 3);
    checkOutput("drop_no_pll", pll_rst, 0);

    // Reset mid-RUN with three relocks recorded.
    relockCycle();
    relockCycle();
    checkOutput("pre_rst_relock", relock_count, 3);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rstrun_state", state, 0);
    checkOutput("rstrun_pll", pll_rst, 1);
    checkOutput("rstrun_sys", sys_rst, 1);
    checkOutput("rstrun_ready", ready, 0);
    checkOutput("rstrun_relock", relock_count, 0);

    // One-cycle glitch on the hold terminal-count edge.
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("glitch_in_hold", state, 2);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 2);
    checkOutput("glitch_to_wait", state, 1);
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("glitch_not_run", state, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("glitch_run", state, 3);

    // Reset mid-HOLD.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 7);
    checkOutput("rsthold_pre", state, 2);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("rsthold_state", state, 0);
    checkOutput("rsthold_pll", pll_rst, 1);
    checkOutput("rsthold_sys", sys_rst, 1);
    checkOutput("rsthold_ready", ready, 0);

    // Lock stuck low: PLL pulses repeat every 36 edges.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 35);
    checkOutput("stuck_pll_e35", pll_rst, 0);
    checkOutput("stuck_state_e35", state, 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("stuck_pll_e36", pll_rst, 1);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("stuck_pll_e40", pll_rst, 0);
    applyStimulus(1'b0, 1'b0, 32);
    checkOutput("stuck_pll_e72", pll_rst, 1);
    checkOutput("stuck_sys", sys_rst, 1);
    checkOutput("stuck_relock", relock_count, 0);

    // Saturation of the relock counter.
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b1, 13);
    checkOutput("sat_start_run", state, 3);
    for (int k = 0; k < 300; k++) relockCycle();
    checkOutput("sat_relock", relock_count, 255);
    checkOutput("sat_ready", ready, 1);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
